idu_decode_queue: RTL and testbench



---
 rtl/idu_decode_queue_pkg.sv | 34 +++
 rtl/idu_dq_prefix_fire.sv | 25 ++
 rtl/idu_decode_queue.sv | 132 +++++++++++++
 tb/tb_idu_decode_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/idu_decode_queue_pkg.sv
// Shared layout and defaults for the decoded-instruction queue between decode and rename.
// The optional lane-0 bypass is enabled with the IDU_DECODE_QUEUE_BYPASS_EN macro.
package idu_decode_queue_pkg;

  localparam int DQ_DEFAULT_DEPTH     = 8;
  localparam int DQ_DEFAULT_DEQ_WIDTH = 2;
  localparam int DQ_PAYLOAD_W         = 128;
  localparam int DQ_PC_W              = 48;
  localparam int DQ_TARGET_W          = 32;

  // Packed decode payload field ranges (MSB/LSB, inclusive).
  localparam int INSTR_MSB       = 31;
  localparam int INSTR_LSB       = 0;
  localparam int IMM_MSB         = 63;
  localparam int IMM_LSB         = 32;
  localparam int LREG_RD_MSB     = 68;
  localparam int LREG_RD_LSB     = 64;
  localparam int LREG_RS1_MSB    = 73;
  localparam int LREG_RS1_LSB    = 69;
  localparam int LREG_RS2_MSB    = 78;
  localparam int LREG_RS2_LSB    = 74;
  localparam int SRC_MSB         = 82;
  localparam int SRC_LSB         = 79;
  localparam int CX_TYPE_MSB     = 86;
  localparam int CX_TYPE_LSB     = 83;
  localparam int ALU_TYPE_MSB    = 90;
  localparam int ALU_TYPE_LSB    = 87;
  localparam int MULDIV_TYPE_MSB = 93;
  localparam int MULDIV_TYPE_LSB = 91;

  localparam int PC_RANGE_MSB    = DQ_PC_W - 1;
  localparam int PC_RANGE_LSB    = 0;

endpackage

// File: rtl/idu_dq_prefix_fire.sv
// In-order ready prefix: a lane fires only if it and every older lane are valid and ready.
module idu_dq_prefix_fire #(
  parameter int DEQ_WIDTH = 2,
  parameter int KW        = $clog2(DEQ_WIDTH + 1)
) (
  input  logic [DEQ_WIDTH-1:0] valid_i,
  input  logic [DEQ_WIDTH-1:0] ready_i,
  output logic [DEQ_WIDTH-1:0] fire_o,
  output logic [KW-1:0]        k_o
);

  logic run;

  always_comb begin
    fire_o = '0;
    k_o    = '0;
    run    = 1'b1;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      run       = run & valid_i[i] & ready_i[i];
      fire_o[i] = run;
      if (run) k_o = k_o + KW'(1);
    end
  end

endmodule

// File: rtl/idu_decode_queue.sv
// Decoded-instruction circular queue: one enqueue per cycle, up to DEQ_WIDTH in-order dequeues.
// Define IDU_DECODE_QUEUE_BYPASS_EN to let an empty queue hand in_* straight to lane 0.
module idu_decode_queue
  import idu_decode_queue_pkg::*;
#(
  parameter int DEPTH     = DQ_DEFAULT_DEPTH,
  parameter int DEQ_WIDTH = DQ_DEFAULT_DEQ_WIDTH,
  parameter int PAYLOAD_W = DQ_PAYLOAD_W,
  parameter int PC_W      = DQ_PC_W,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           flush_valid,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PAYLOAD_W-1:0]           in_payload,
  input  logic [PC_W-1:0]                in_pc,
  input  logic                           in_predicttaken,
  input  logic [31:0]                    in_predicttarget,
  output logic [DEQ_WIDTH-1:0]           out_valid,
  input  logic [DEQ_WIDTH-1:0]           out_ready,
  output logic [DEQ_WIDTH*PAYLOAD_W-1:0] out_payload,
  output logic [DEQ_WIDTH*PC_W-1:0]      out_pc,
  output logic [DEQ_WIDTH-1:0]           out_predicttaken,
  output logic [DEQ_WIDTH*32-1:0]        out_predicttarget,
  output logic [CNT_W-1:0]               count,
  output logic                           empty,
  output logic                           full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int KW    = $clog2(DEQ_WIDTH + 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PAYLOAD_W-1:0] mem_payload_q [DEPTH];
  logic [PC_W-1:0]      mem_pc_q      [DEPTH];
  logic                 mem_pt_q      [DEPTH];
  logic [31:0]          mem_tgt_q     [DEPTH];

  logic [DEQ_WIDTH-1:0] fire;
  logic [KW-1:0]        k;
  logic [KW-1:0]        deq_k;
  logic                 bypass_active;
  logic                 bypass_take;
  logic                 enq;

  // in_ready depends only on occupancy, so rename never reaches decode combinationally.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));

`ifdef IDU_DECODE_QUEUE_BYPASS_EN
  assign bypass_active = (count_q == '0) & in_valid & ~flush_valid;
`else
  assign bypass_active = 1'b0;
`endif

  always_comb begin
    out_valid         = '0;
    out_payload       = '0;
    out_pc            = '0;
    out_predicttaken  = '0;
    out_predicttarget = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      out_valid[i]                          = (count_q > CNT_W'(i)) & ~flush_valid;
      out_payload[i*PAYLOAD_W +: PAYLOAD_W] = mem_payload_q[rd_ptr_q + PTR_W'(i)];
      out_pc[i*PC_W +: PC_W]                = mem_pc_q[rd_ptr_q + PTR_W'(i)];
      out_predicttaken[i]                   = mem_pt_q[rd_ptr_q + PTR_W'(i)];
      out_predicttarget[i*32 +: 32]         = mem_tgt_q[rd_ptr_q + PTR_W'(i)];
    end
    if (bypass_active) begin
      out_valid[0]                = 1'b1;
      out_payload[PAYLOAD_W-1:0]  = in_payload;
      out_pc[PC_W-1:0]            = in_pc;
      out_predicttaken[0]         = in_predicttaken;
      out_predicttarget[31:0]     = in_predicttarget;
    end
  end

  idu_dq_prefix_fire #(
    .DEQ_WIDTH (DEQ_WIDTH),
    .KW        (KW)
  ) u_prefix_fire (
    .valid_i (out_valid),
    .ready_i (out_ready),
    .fire_o  (fire),
    .k_o     (k)
  );

  // A bypassed instruction consumed on lane 0 never touches storage or pointers.
  assign bypass_take = bypass_active & fire[0];
  assign enq         = in_valid & in_ready & ~flush_valid & ~bypass_take;
  assign deq_k       = bypass_take ? '0 : k;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(deq_k);
    wr_ptr_d = wr_ptr_q + PTR_W'(enq);
    count_d  = count_q + CNT_W'(enq) - CNT_W'(deq_k);
    if (flush_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      mem_payload_q[wr_ptr_q] <= in_payload;
      mem_pc_q[wr_ptr_q]      <= in_pc;
      mem_pt_q[wr_ptr_q]      <= in_predicttaken;
      mem_tgt_q[wr_ptr_q]     <= in_predicttarget;
    end
  end

endmodule

// File: tb/tb_idu_decode_queue.sv
// Randomised scoreboard bench for idu_decode_queue against a queue-based reference model.
module tb_idu_decode_queue;

  localparam int DEPTH     = 8;
  localparam int DEQ_WIDTH = 2;
  localparam int PAYLOAD_W = 128;
  localparam int PC_W      = 48;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [PC_W-1:0]      pc;
    logic                 pt;
    logic [31:0]          tgt;
  } pkt_t;

  logic                           clock;
  logic                           reset_n;
  logic                           flush_valid;
  logic                           in_valid;
  logic                           in_ready;
  logic [PAYLOAD_W-1:0]           in_payload;
  logic [PC_W-1:0]                in_pc;
  logic                           in_predicttaken;
  logic [31:0]                    in_predicttarget;
  logic [DEQ_WIDTH-1:0]           out_valid;
  logic [DEQ_WIDTH-1:0]           out_ready;
  logic [DEQ_WIDTH*PAYLOAD_W-1:0] out_payload;
  logic [DEQ_WIDTH*PC_W-1:0]      out_pc;
  logic [DEQ_WIDTH-1:0]           out_predicttaken;
  logic [DEQ_WIDTH*32-1:0]        out_predicttarget;
  logic [CNT_W-1:0]               count;
  logic                           empty;
  logic                           full;

  pkt_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  idu_decode_queue #(
    .DEPTH     (DEPTH),
    .DEQ_WIDTH (DEQ_WIDTH),
    .PAYLOAD_W (PAYLOAD_W),
    .PC_W      (PC_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .flush_valid       (flush_valid),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_payload        (in_payload),
    .in_pc             (in_pc),
    .in_predicttaken   (in_predicttaken),
    .in_predicttarget  (in_predicttarget),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_payload       (out_payload),
    .out_pc            (out_pc),
    .out_predicttaken  (out_predicttaken),
    .out_predicttarget (out_predicttarget),
    .count             (count),
    .empty             (empty),
    .full              (full)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Driver: new inputs just after the rising edge, held for the whole cycle.
  task automatic step(input logic v, input logic [PC_W-1:0] pc,
                      input logic [DEQ_WIDTH-1:0] ordy, input logic fl);
    @(posedge clock);
    #1;
    in_valid         = v;
    in_pc            = pc;
    in_payload       = {$urandom, $urandom, $urandom, $urandom};
    in_predicttaken  = 1'($urandom_range(0, 1));
    in_predicttarget = $urandom;
    out_ready        = ordy;
    flush_valid      = fl;
  endtask

  // Monitor and scoreboard: compares at the falling edge, then retires what the handshake consumes.
  always @(negedge clock) begin
    if (mon_en) begin
      int   sz;
      int   n_fire;
      logic bypass;
      logic accept;
      logic [DEQ_WIDTH-1:0] exp_v;
      pkt_t in_pkt;
      pkt_t lane_exp;
      sz     = exp_q.size();
      in_pkt = '{payload: in_payload, pc: in_pc, pt: in_predicttaken, tgt: in_predicttarget};
      bypass = 1'b0;
`ifdef IDU_DECODE_QUEUE_BYPASS_EN
      bypass = (sz == 0) && in_valid && !flush_valid;
`endif
      chk("count",    128'(count),    128'(sz));
      chk("empty",    128'(empty),    128'(sz == 0));
      chk("full",     128'(full),     128'(sz == DEPTH));
      chk("in_ready", 128'(in_ready), 128'(sz != DEPTH));
      for (int i = 0; i < DEQ_WIDTH; i++)
        exp_v[i] = !flush_valid && ((i < sz) || (bypass && i == 0));
      chk("out_valid", 128'(out_valid), 128'(exp_v));
      for (int i = 0; i < DEQ_WIDTH; i++) begin
        if (exp_v[i]) begin
          lane_exp = (bypass && i == 0) ? in_pkt : exp_q[i];
          chk($sformatf("lane%0d_pc", i),      128'(out_pc[i*PC_W +: PC_W]),            128'(lane_exp.pc));
          chk($sformatf("lane%0d_payload", i), out_payload[i*PAYLOAD_W +: PAYLOAD_W],    lane_exp.payload);
          chk($sformatf("lane%0d_ptaken", i),  128'(out_predicttaken[i]),               128'(lane_exp.pt));
          chk($sformatf("lane%0d_target", i),  128'(out_predicttarget[i*32 +: 32]),     128'(lane_exp.tgt));
        end
      end
      n_fire = 0;
      for (int i = 0; i < DEQ_WIDTH; i++)
        if (exp_v[i] && out_ready[i] && n_fire == i) n_fire++;
      if (flush_valid) begin
        exp_q.delete();
      end else begin
        accept = in_valid && (sz != DEPTH);
        if (bypass && n_fire > 0) begin
          accept = 1'b0;
        end else begin
          for (int i = 0; i < n_fire; i++) void'(exp_q.pop_front());
        end
        if (accept) exp_q.push_back(in_pkt);
      end
    end
  end

  initial begin
    logic [PC_W-1:0] pc;
    reset_n          = 1'b0;
    flush_valid      = 1'b0;
    in_valid         = 1'b0;
    in_payload       = '0;
    in_pc            = '0;
    in_predicttaken  = 1'b0;
    in_predicttarget = '0;
    out_ready        = '0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Idle after reset
    step(1'b0, '0, 2'b00, 1'b0);
    step(1'b0, '0, 2'b00, 1'b0);

    // Three entries held, then out-of-order ready ignored, then dual retire
    step(1'b1, 48'h100, 2'b00, 1'b0);
    step(1'b1, 48'h104, 2'b00, 1'b0);
    step(1'b1, 48'h108, 2'b00, 1'b0);
    step(1'b0, '0, 2'b10, 1'b0);
    step(1'b0, '0, 2'b10, 1'b0);
    step(1'b0, '0, 2'b11, 1'b0);
    step(1'b0, '0, 2'b11, 1'b0);
    step(1'b0, '0, 2'b00, 1'b0);

    // Fill to full, push against full, then dequeue two while in_valid is held
    pc = 48'h200;
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b1, pc, 2'b00, 1'b0);
      pc += 48'h4;
    end
    step(1'b1, pc, 2'b11, 1'b0);
    step(1'b0, '0, 2'b00, 1'b0);
    repeat (4) step(1'b0, '0, 2'b11, 1'b0);

    // Wrap-around: continuous enqueue with single-lane dequeue
    pc = 48'h1000;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, pc, 2'b01, 1'b0);
      pc += 48'h4;
    end
    repeat (12) step(1'b0, '0, 2'b01, 1'b0);

    // Flush with five queued entries and a new instruction offered
    pc = 48'h3000;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, pc, 2'b00, 1'b0);
      pc += 48'h4;
    end
    step(1'b1, 48'hDEAD0, 2'b11, 1'b1);
    step(1'b0, '0, 2'b11, 1'b0);
    step(1'b0, '0, 2'b11, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), {16'h0, $urandom},
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 63) == 0));
    end
    repeat (8) step(1'b0, '0, 2'b11, 1'b0);
    @(posedge clock);
    #1;
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
